// File: rtl/div_iter_unit_pkg.sv
// ============================================================================
//  Module   : div_iter_unit_pkg
//  Brief    : Shared state encoding and sizing helper for the iterative divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_t;

    // Iteration counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter_unit_sub_stage.sv
// ============================================================================
//  Module   : div_iter_unit_sub_stage
//  Brief    : N-bit subtractor a - b from chained 4-bit carry-lookahead slices.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_iter_unit_sub_stage #(
    parameter int N = 33
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_sign
);

    localparam int c_NSL  = (N + 3) / 4;
    localparam int c_LAST = N - 4 * (c_NSL - 1);

    for (genvar i = 0; i < c_NSL; i++) begin : g_slice
        localparam int c_LO = 4 * i;
        localparam int c_L  = ((N - c_LO) < 4) ? (N - c_LO) : 4;

        logic [c_L-1:0] w_g;
        logic [c_L-1:0] w_p;
        logic [c_L:0]   w_k;
        logic           w_ci;
        logic           v_carry;
        logic           v_pp;

        // Subtraction is a + ~b + 1: the +1 enters as carry-in of slice 0.
        if (i == 0) begin : g_first
            assign w_ci = 1'b1;
        end else begin : g_chain
            assign w_ci = g_slice[i-1].w_k[4];
        end

        assign w_g = i_a[c_LO +: c_L] & ~i_b[c_LO +: c_L];
        assign w_p = i_a[c_LO +: c_L] ^ ~i_b[c_LO +: c_L];

        always_comb begin
            w_k     = '0;
            v_carry = 1'b0;
            v_pp    = 1'b1;
            w_k[0]  = w_ci;
            for (int j = 0; j < c_L; j++) begin
                v_carry = 1'b0;
                v_pp    = 1'b1;
                for (int m = j; m >= 0; m--) begin
                    v_carry = v_carry | (w_g[m] & v_pp);
                    v_pp    = v_pp & w_p[m];
                end
                w_k[j+1] = v_carry | (v_pp & w_ci);
            end
        end

        assign o_diff[c_LO +: c_L] = w_p ^ w_k[c_L-1:0];
    end

    // No carry out of the top slice means a borrow, i.e. a < b unsigned.
    assign o_sign = ~g_slice[c_NSL-1].w_k[c_LAST];

endmodule

`default_nettype wire

// File: rtl/div_iter_unit.sv
// ============================================================================
//  Module   : div_iter_unit
//  Brief    : Multi-cycle restoring divider (DIV/DIVU), one quotient bit/cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ZERO  = '0;

    div_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd_raw;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_dvd_neg;
    logic [WIDTH-1:0]   w_dvs_neg;
    logic               w_dvd_nz;
    logic               w_dvs_nz;
    logic               w_dvd_is_neg;
    logic               w_dvs_is_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_borrow;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_neg;
    logic [WIDTH-1:0]   w_rem_neg;
    logic               w_quo_nz;
    logic               w_rem_nz;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    // Operand magnitudes; 0 - x also reports x != 0 through its borrow.
    div_iter_unit_sub_stage #(.N(WIDTH)) u_neg_dvd (
        .i_a    (c_ZERO),
        .i_b    (dividend),
        .o_diff (w_dvd_neg),
        .o_sign (w_dvd_nz)
    );

    div_iter_unit_sub_stage #(.N(WIDTH)) u_neg_dvs (
        .i_a    (c_ZERO),
        .i_b    (divisor),
        .o_diff (w_dvs_neg),
        .o_sign (w_dvs_nz)
    );

    assign w_dvd_is_neg = signed_op & dividend[WIDTH-1] & w_dvd_nz;
    assign w_dvs_is_neg = signed_op & divisor[WIDTH-1];
    assign w_dvd_mag    = w_dvd_is_neg ? w_dvd_neg : dividend;
    assign w_dvs_mag    = w_dvs_is_neg ? w_dvs_neg : divisor;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};

    div_iter_unit_sub_stage #(.N(WIDTH + 1)) u_trial (
        .i_a    (w_rem_sh),
        .i_b    ({1'b0, r_dvs}),
        .o_diff (w_trial),
        .o_sign (w_trial_borrow)
    );

    // A borrow restores the shifted remainder, which is still below the divisor.
    assign w_rem_next = w_trial_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];

    div_iter_unit_sub_stage #(.N(WIDTH)) u_neg_quo (
        .i_a    (c_ZERO),
        .i_b    (r_quo),
        .o_diff (w_quo_neg),
        .o_sign (w_quo_nz)
    );

    div_iter_unit_sub_stage #(.N(WIDTH)) u_neg_rem (
        .i_a    (c_ZERO),
        .i_b    (r_rem),
        .o_diff (w_rem_neg),
        .o_sign (w_rem_nz)
    );

    assign w_q_final = r_dz ? {WIDTH{1'b1}} : ((r_neg_q & w_quo_nz) ? w_quo_neg : r_quo);
    assign w_r_final = r_dz ? r_dvd_raw : ((r_neg_r & w_rem_nz) ? w_rem_neg : r_rem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dvd_raw     <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_ITER;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_mag;
                        r_dvs     <= w_dvs_mag;
                        r_dvd_raw <= dividend;
                        r_neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r   <= signed_op & dividend[WIDTH-1];
                        r_dz      <= ~w_dvs_nz;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    r_state       <= ST_DONE;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_quotient    <= w_q_final;
                    r_remainder   <= w_r_final;
                    r_div_by_zero <= r_dz;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
// ============================================================================
//  Module   : tb_div_iter_unit
//  Brief    : Directed and randomised self-checking bench for div_iter_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_errors;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one op; returns at the negedge inside the done cycle (or on timeout).
    // inj_at > 0 pulses a conflicting start in that cycle of the running op.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input int inj_at,
                          output int lat, output bit busy_ok);
        if (!b2b) @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == inj_at) begin
                start     = 1'b1;
                signed_op = ~s;
                dividend  = 32'd5;
                divisor   = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        string       tag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int    lat;
        bit    bok;
        bit    seen_done;
        logic [31:0] ea, eb, eq, er;
        logic        es;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div_m7_2"};
        vecs[1] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, "div_7_m2"};
        vecs[2] = '{1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      1'b1, "divu_by0"};
        vecs[3] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, "divu_after_by0"};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, "div_ovf"};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, "divu_max_1"};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);

        // Basic unsigned op with latency, busy window and done pulse.
        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, lat, bok);
        check("t1_lat", lat, 34);
        check("t1_busy_window", bok, 1);
        check("t1_busy_in_done", busy, 0);
        check("t1_q", quotient, 14);
        check("t1_r", remainder, 2);
        check("t1_dz", div_by_zero, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_q_held", quotient, 14);

        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, 0, lat, bok);
            check({vecs[i].tag, "_lat"}, lat, 34);
            check({vecs[i].tag, "_q"}, quotient, vecs[i].q);
            check({vecs[i].tag, "_r"}, remainder, vecs[i].r);
            check({vecs[i].tag, "_dz"}, div_by_zero, vecs[i].dz);
        end

        // Start while busy is ignored.
        run_op(1'b0, 32'd1000, 32'd10, 1'b0, 10, lat, bok);
        check("t5_ign_lat", lat, 34);
        check("t5_ign_q", quotient, 100);
        check("t5_ign_r", remainder, 0);

        // Start in the DONE cycle is accepted.
        run_op(1'b0, 32'd20, 32'd3, 1'b0, 0, lat, bok);
        check("t5_a_q", quotient, 6);
        check("t5_a_r", remainder, 2);
        run_op(1'b0, 32'd50, 32'd5, 1'b1, 0, lat, bok);
        check("t5_b2b_lat", lat, 34);
        check("t5_b2b_q", quotient, 10);
        check("t5_b2b_r", remainder, 0);

        // Random sweep against the language's own division operators.
        for (int n = 0; n < 24; n++) begin
            es = n[0];
            ea = $urandom();
            eb = (n < 12) ? ($urandom() >> $urandom_range(0, 30)) : $urandom();
            if (eb == 32'd0) eb = 32'd3;
            if (es && ea == 32'h8000_0000 && eb == 32'hFFFF_FFFF) eb = 32'd5;
            if (es) begin
                eq = $signed(ea) / $signed(eb);
                er = $signed(ea) % $signed(eb);
            end else begin
                eq = ea / eb;
                er = ea % eb;
            end
            run_op(es, ea, eb, 1'b0, 0, lat, bok);
            check("rnd_q", quotient, eq);
            check("rnd_r", remainder, er);
        end

        // Asynchronous reset mid-operation aborts without a done pulse.
        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, lat, bok);
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'h1234;
        divisor   = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_q", quotient, 0);
        check("t6_r", remainder, 0);
        check("t6_dz", div_by_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("t6_no_done", seen_done, 0);
        run_op(1'b0, 32'h1234, 32'h10, 1'b0, 0, lat, bok);
        check("t6_fresh_lat", lat, 34);
        check("t6_fresh_q", quotient, 32'h123);
        check("t6_fresh_r", remainder, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
